// File: rtl/dma_req_splitter_pkg.sv
// Request and status types shared by the DMA request splitter and its users.
package dma_req_splitter_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] num_bytes;
        logic [3:0]  cache_src;
        logic [3:0]  cache_dst;
        logic [1:0]  burst_src;
        logic [1:0]  burst_dst;
        logic        decouple_rw;
        logic        deburst;
        logic        serialize;
    } dma_req_t;

    typedef struct packed {
        logic backend_idle;
        logic trans_complete;
    } dma_meta_t;

endpackage

// File: rtl/dma_req_splitter.sv
// Splits one DMA transfer into sub-requests that never cross a ChunkBytes
// boundary on the destination side, and keeps at most MaxOutstanding
// sub-requests in flight at the backend.
module dma_req_splitter
    import dma_req_splitter_pkg::*;
#(
    parameter int unsigned ChunkBytes     = 256,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  dma_req_t  req_i,
    input  logic      req_valid_i,
    output logic      req_ready_o,
    output dma_req_t  burst_req_o,
    output logic      burst_valid_o,
    input  logic      burst_ready_i,
    input  logic      burst_done_i,
    output dma_meta_t meta_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic [1:0] {
        IDLE,
        SPLIT,
        DRAIN
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] out_q;
    logic [CntW-1:0] out_d;
    dma_req_t        req_q;
    dma_req_t        burst_q;
    logic [31:0]     src_q;
    logic [31:0]     dst_q;
    logic [31:0]     rem_q;
    logic            valid_q;
    logic            tc_q;
    logic            idle_q;

    logic            accept;
    logic            hs;
    logic            room_ok;
    logic [31:0]     nxt_src;
    logic [31:0]     nxt_dst;
    logic [31:0]     nxt_rem;
    logic [31:0]     nxt_chunk;
    logic [31:0]     acc_chunk;

    // Bytes that fit before the next destination chunk boundary, capped by what is left.
    function automatic logic [31:0] chunk_of(input logic [31:0] rem, input logic [31:0] dst);
        logic [31:0] room;
        room = 32'(ChunkBytes) - (dst & 32'(ChunkBytes - 1));
        return (rem < room) ? rem : room;
    endfunction

    function automatic dma_req_t make_burst(input dma_req_t base, input logic [31:0] s,
                                            input logic [31:0] d, input logic [31:0] n);
        dma_req_t b;
        b           = base;
        b.src       = s;
        b.dst       = d;
        b.num_bytes = n;
        return b;
    endfunction

    assign req_ready_o         = (state_q == IDLE) & ~tc_q & ~rst_i;
    assign burst_req_o         = burst_q;
    assign burst_valid_o       = valid_q;
    assign meta_o.backend_idle = idle_q;
    assign meta_o.trans_complete = tc_q;

    // Handshake detection, outstanding-count update and next sub-request geometry.
    always_comb begin
        accept    = req_valid_i & req_ready_o;
        hs        = valid_q & burst_ready_i;
        out_d     = out_q;
        if (hs && !burst_done_i) begin
            out_d = out_q + CntW'(1);
        end else if (!hs && burst_done_i && (out_q != '0)) begin
            out_d = out_q - CntW'(1);
        end
        room_ok   = out_d < CntW'(MaxOutstanding);
        nxt_src   = src_q + burst_q.num_bytes;
        nxt_dst   = dst_q + burst_q.num_bytes;
        nxt_rem   = rem_q - burst_q.num_bytes;
        nxt_chunk = chunk_of(nxt_rem, nxt_dst);
        acc_chunk = chunk_of(req_i.num_bytes, req_i.dst);
    end

    // Control FSM with registered sub-request and status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            out_q   <= '0;
            req_q   <= '0;
            burst_q <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            tc_q    <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            out_q <= out_d;
            tc_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    idle_q <= (out_d == '0);
                    if (accept) begin
                        req_q <= req_i;
                        if (req_i.num_bytes != '0) begin
                            state_q <= SPLIT;
                            src_q   <= req_i.src;
                            dst_q   <= req_i.dst;
                            rem_q   <= req_i.num_bytes;
                            burst_q <= make_burst(req_i, req_i.src, req_i.dst, acc_chunk);
                            valid_q <= 1'b1;
                            idle_q  <= 1'b0;
                        end else begin
                            tc_q <= 1'b1;
                        end
                    end
                end
                SPLIT: begin
                    idle_q <= 1'b0;
                    if (hs) begin
                        src_q   <= nxt_src;
                        dst_q   <= nxt_dst;
                        rem_q   <= nxt_rem;
                        burst_q <= make_burst(req_q, nxt_src, nxt_dst, nxt_chunk);
                        if (nxt_rem == '0) begin
                            state_q <= DRAIN;
                            valid_q <= 1'b0;
                        end else begin
                            valid_q <= room_ok;
                        end
                    end else begin
                        valid_q <= room_ok;
                    end
                end
                DRAIN: begin
                    valid_q <= 1'b0;
                    idle_q  <= 1'b0;
                    if (out_q == '0) begin
                        state_q <= IDLE;
                        tc_q    <= 1'b1;
                        idle_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
